// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared bus definitions for the memory port arbiter: default bus widths,
// the FSM state encodings, the owner encoding and a small helper used by the
// tie-break logic.
// No ports (package).

package mem_port_arbiter_pkg;

    // Default bus widths of the shared memory port
    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;
    localparam int STRB_W   = 4;

    // FSM state encodings (plain constants so older tools can consume them)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    // Which requester owns the current transaction
    typedef logic owner_t;
    localparam owner_t OWN_INST = 1'b0;
    localparam owner_t OWN_DATA = 1'b1;

    // The requester that was not granted last time
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_INST) ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick
// Chooses the owner of the next memory transaction from the two requesters.
// Build option: ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the
// requester that was not granted last; otherwise data always wins a tie.
// Ports:
//   inst_req  in  1  fetch requester is asking
//   data_req  in  1  load/store requester is asking
//   last      in  1  owner of the previous grant (ignored in fixed priority)
//   owner     out 1  selected owner (OWN_INST / OWN_DATA); don't-care when
//                    nobody requests

module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
    input  logic last,
    output logic owner
);

`ifdef ARB_ROUND_ROBIN_EN
    // Round robin: a single requester always wins, a tie alternates
    always_comb begin
        owner = OWN_DATA;
        if (inst_req && data_req) begin
            owner = other_owner(last);
        end else if (inst_req) begin
            owner = OWN_INST;
        end
    end
`else
    // Fixed priority: inst only gets the port when data is not asking.
    // The previous-grant input has no meaning here.
    logic unusedLast;
    assign unusedLast = last;

    always_comb begin
        owner = (inst_req && !data_req) ? OWN_INST : OWN_DATA;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between an instruction-fetch requester and a
// load/store requester, with at most one transaction outstanding. Each
// transaction walks IDLE -> ADDR -> DATA; the winning request is latched in
// IDLE so the memory side sees stable fields for as long as it stalls.
// Build option: ARB_ROUND_ROBIN_EN -- round-robin tie break with a 1-bit
// last-grant register; undefined gives fixed data-over-inst priority.
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   flush                       drop the response of an in-flight fetch
//   inst_req/inst_addr          fetch request and address
//   inst_addr_ok/inst_data_ok   fetch accept / response pulses
//   inst_rdata                  fetched word (0 unless inst_data_ok)
//   data_req/data_wr/data_wstrb/data_addr/data_wdata
//                               load/store request fields
//   data_addr_ok/data_data_ok   load/store accept / response pulses
//   data_rdata                  load word (0 unless data_data_ok)
//   mem_req/mem_wr/mem_wstrb/mem_addr/mem_wdata
//                               shared memory request side
//   mem_addr_ok/mem_data_ok/mem_rdata
//                               shared memory handshake / response

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int DATA_W = DATA_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state_q,   state_d;
    owner_t              owner_q,   owner_d;
    logic                wr_q,      wr_d;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic                discard_q, discard_d;

    owner_t              pickOwner;
    owner_t              lastGrant;
    logic                anyReq;
    logic                inAddr;
    logic                inData;
    logic                instOwns;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t              last_q, last_d;
    assign lastGrant = last_q;
`else
    assign lastGrant = OWN_DATA;
`endif

    assign anyReq   = inst_req | data_req;
    assign inAddr   = (state_q == ST_ADDR);
    assign inData   = (state_q == ST_DATA);
    assign instOwns = (owner_q == OWN_INST);

    arb_pick u_arb_pick (
        .inst_req (inst_req),
        .data_req (data_req),
        .last     (lastGrant),
        .owner    (pickOwner)
    );

    // Next-state logic: grant and latch in IDLE, then wait for the two
    // memory handshakes. Handshakes seen in the wrong state fall through to
    // the hold defaults and are ignored.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        discard_d = discard_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    state_d = ST_ADDR;
                    owner_d = pickOwner;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = pickOwner;
`endif
                    if (pickOwner == OWN_DATA) begin
                        wr_d    = data_wr;
                        wstrb_d = data_wstrb;
                        addr_d  = data_addr;
                        wdata_d = data_wdata;
                    end else begin
                        // Fetches are always full-word reads
                        wr_d    = 1'b0;
                        wstrb_d = '0;
                        addr_d  = inst_addr;
                        wdata_d = '0;
                    end
                end
            end
            ST_ADDR: begin
                if (mem_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush during an in-flight fetch marks its response as stale; the
        // mark lives only until the transaction retires.
        if (!(state_q == ST_IDLE) && instOwns && flush) begin
            discard_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            discard_d = 1'b0;
        end
    end

    // State and request latch registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_INST;
            wr_q      <= 1'b0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            discard_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= OWN_DATA;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            discard_q <= discard_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    // Memory side is driven straight from the latch so it cannot move while
    // the memory stalls mem_addr_ok.
    assign mem_req   = inAddr;
    assign mem_wr    = wr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Requester handshakes; a same-cycle flush also hides the fetch response
    // since the discard register would only catch it one cycle later.
    assign inst_addr_ok = inAddr & instOwns & mem_addr_ok;
    assign data_addr_ok = inAddr & ~instOwns & mem_addr_ok;
    assign inst_data_ok = inData & instOwns & mem_data_ok & ~discard_q & ~flush;
    assign data_data_ok = inData & ~instOwns & mem_data_ok;

    assign inst_rdata = inst_data_ok ? mem_rdata : '0;
    assign data_rdata = data_data_ok ? mem_rdata : '0;

endmodule
